// File: rtl/mem_read_display_pkg.sv
// ============================================================================
// Module      : mem_read_display_pkg
// Description : Shared state encoding, BCD constants and nibble-adjust helper
//               for the RAM read/display initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_read_display_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_CONV = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_WAIT = c_ST_WAIT,
        ST_CONV = c_ST_CONV,
        ST_DONE = c_ST_DONE
    } state_t;

    localparam int         c_BCD_W      = 12;
    localparam logic [3:0] c_ADJ_THRESH = 4'd5;
    localparam logic [3:0] c_ADJ_OFFSET = 4'd3;

    // Adds 3 to every nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [c_BCD_W-1:0] bcd_adjust(input logic [c_BCD_W-1:0] bcd);
        logic [c_BCD_W-1:0] w_adj;
        w_adj = bcd;
        for (int i = 0; i < c_BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= c_ADJ_THRESH) begin
                w_adj[4*i +: 4] = bcd[4*i +: 4] + c_ADJ_OFFSET;
            end
        end
        return w_adj;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_read_display_bin_to_bcd_seq.sv
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential shift-add-3 binary to 3-digit BCD converter, one
//               input bit per clock after a load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import mem_read_display_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic [DATA_W-1:0]  i_bin,
    output logic               o_done,
    output logic [c_BCD_W-1:0] o_bcd
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]         r_bin;
    logic [c_BCD_W-1:0]        r_bcd;
    logic [c_CNT_W-1:0]        r_bit_cnt;
    logic [c_BCD_W+DATA_W-1:0] w_shift;

    assign w_shift = {bcd_adjust(r_bcd), r_bin} << 1;
    // o_bcd is the post-shift accumulator, so on the done edge it is the result.
    assign o_bcd   = w_shift[c_BCD_W+DATA_W-1 -: c_BCD_W];
    assign o_done  = (r_bit_cnt == c_CNT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_bin     <= i_bin;
            r_bcd     <= '0;
            r_bit_cnt <= c_CNT_W'(DATA_W);
        end else if (r_bit_cnt != '0) begin
            r_bin     <= w_shift[DATA_W-1:0];
            r_bcd     <= o_bcd;
            r_bit_cnt <= r_bit_cnt - c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_read_display.sv
// ============================================================================
// Module      : mem_read_display
// Description : Read-side initiator for the 8-bit board RAM; fetches a byte on
//               request and presents it as three BCD digits.
//               Optional macro MEM_READ_DISPLAY_SCAN_EN adds the scan input
//               for automatic incrementing-address reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_read_display
    import mem_read_display_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
`ifdef MEM_READ_DISPLAY_SCAN_EN
    input  logic              scan,
`endif
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              valid,
    output logic [DATA_W-1:0] value,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        units
);

    localparam int c_WAIT_W = $clog2(RD_LAT + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic                w_load;
    logic                w_conv_done;
    logic [c_BCD_W-1:0]  w_bcd;

    logic [ADDR_W-1:0]   r_mem_address;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0]   r_cap;
    logic [DATA_W-1:0]   r_value;
    logic [c_BCD_W-1:0]  r_bcd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_addr = req_addr;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_issue = 1'b1;
                end
`ifdef MEM_READ_DISPLAY_SCAN_EN
                else if (scan) begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_mem_address + ADDR_W'(1);
                end
`endif
                if (w_issue) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_W'(1)) begin
                    w_load       = 1'b1;
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_conv_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_address <= '0;
            r_wait_cnt    <= '0;
            r_cap         <= '0;
            r_value       <= '0;
            r_bcd         <= '0;
        end else begin
            if (w_issue) begin
                r_mem_address <= w_issue_addr;
                r_wait_cnt    <= c_WAIT_W'(RD_LAT);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
            end
            if (w_load) begin
                r_cap <= mem_q;
            end
            if ((r_state == ST_CONV) && w_conv_done) begin
                r_value <= r_cap;
                r_bcd   <= w_bcd;
            end
        end
    end

    bin_to_bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_load),
        .i_bin  (mem_q),
        .o_done (w_conv_done),
        .o_bcd  (w_bcd)
    );

    assign busy        = (r_state != ST_IDLE);
    assign valid       = (r_state == ST_DONE);
    assign mem_address = r_mem_address;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;
    assign value       = r_value;
    assign hundreds    = r_bcd[11:8];
    assign tens        = r_bcd[7:4];
    assign units       = r_bcd[3:0];

endmodule

`default_nettype wire

// File: tb/tb_mem_read_display.sv
// ============================================================================
// Module      : tb_mem_read_display
// Description : Scoreboard bench for mem_read_display; RD_LAT=1 and RD_LAT=2
//               instances against a RAM model and a timing/decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_read_display;

    localparam int c_DATA_W = 8;
    localparam int c_LAT1   = 1;
    localparam int c_LAT2   = 2;
    localparam int c_L1     = c_LAT1 + c_DATA_W;
    localparam int c_L2     = c_LAT2 + c_DATA_W;

    typedef struct {
        int value;
        int h;
        int t;
        int u;
        int cyc;
    } exp_t;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       r_reset = 1'b1, r_reset2 = 1'b1;
    logic       r_req = 1'b0, r_req2 = 1'b0, r_scan = 1'b0;
    logic [7:0] r_req_addr = '0, r_req_addr2 = '0;
    logic [7:0] ram [256];

    logic       w_busy1, w_wren1, w_valid1, w_busy2, w_wren2, w_valid2;
    logic [7:0] w_addr1, w_data1, w_q1, w_value1, w_addr2, w_data2, w_value2;
    logic [7:0] r_q2 = '0;
    logic [3:0] w_h1, w_t1, w_u1, w_h2, w_t2, w_u2;

    assign w_q1 = ram[w_addr1];
    always @(posedge clock) r_q2 <= ram[w_addr2];

    mem_read_display #(.ADDR_W(8), .DATA_W(c_DATA_W), .RD_LAT(c_LAT1)) dut1 (
        .clock(clock), .reset(r_reset), .req(r_req), .req_addr(r_req_addr),
`ifdef MEM_READ_DISPLAY_SCAN_EN
        .scan(r_scan),
`endif
        .busy(w_busy1), .mem_address(w_addr1), .mem_wren(w_wren1), .mem_data(w_data1),
        .mem_q(w_q1), .valid(w_valid1), .value(w_value1),
        .hundreds(w_h1), .tens(w_t1), .units(w_u1)
    );

    mem_read_display #(.ADDR_W(8), .DATA_W(c_DATA_W), .RD_LAT(c_LAT2)) dut2 (
        .clock(clock), .reset(r_reset2), .req(r_req2), .req_addr(r_req_addr2),
`ifdef MEM_READ_DISPLAY_SCAN_EN
        .scan(1'b0),
`endif
        .busy(w_busy2), .mem_address(w_addr2), .mem_wren(w_wren2), .mem_data(w_data2),
        .mem_q(r_q2), .valid(w_valid2), .value(w_value2),
        .hundreds(w_h2), .tens(w_t2), .units(w_u2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input int a, input int vcyc);
        exp_t e;
        e.value = ram[a];
        e.h     = e.value / 100;
        e.t     = (e.value / 10) % 10;
        e.u     = e.value % 10;
        e.cyc   = vcyc;
        return e;
    endfunction

    // Model state for dut1: edge numbers at which things happen.
    exp_t q1[$];
    exp_t hold1;
    int   next_free1 = 1 << 30;
    int   busy_from1 = 1, busy_to1 = 0;
    int   addr_pend1 = 0, addr_cyc1 = -1, rst_cyc1 = -1, model_addr1 = 0;
    bit   start1 = 0;

    task automatic issue1(input int a, input int t_edge);
        q1.push_back(make_exp(a, t_edge + c_L1));
        next_free1  = t_edge + c_L1 + 2;
        busy_from1  = t_edge;
        busy_to1    = t_edge + c_L1;
        addr_pend1  = a;
        addr_cyc1   = t_edge;
        model_addr1 = a;
    endtask

    task automatic do_req1(input int a, input int hold_cycles);
        for (int k = 0; k < hold_cycles; k++) begin
            @(posedge clock); #1;
            r_req      = 1'b1;
            r_req_addr = 8'(a);
            if (cyc + 1 >= next_free1) issue1(a, cyc + 1);
        end
        @(posedge clock); #1;
        r_req = 1'b0;
    endtask

    task automatic apply_reset1();
        @(posedge clock); #1;
        r_reset = 1'b1;
        while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
        if (busy_to1 > cyc) busy_to1 = cyc;
        rst_cyc1    = cyc + 1;
        next_free1  = cyc + 2;
        model_addr1 = 0;
        @(posedge clock); #1;
        r_reset = 1'b0;
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (q1.size() > 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (q1.size() > 0) begin
            check("drain_timeout_dut1", q1.size(), 0);
            q1.delete();
        end
        while (cyc + 1 < next_free1) begin
            @(posedge clock); #1;
        end
    endtask

`ifdef MEM_READ_DISPLAY_SCAN_EN
    task automatic scan_run(input int n_reads);
        r_scan = 1'b1;
        for (int k = 0; k < n_reads; k++) begin
            while (cyc + 1 < next_free1) begin
                @(posedge clock); #1;
            end
            issue1((model_addr1 + 1) % 256, cyc + 1);
            @(posedge clock); #1;
        end
        r_scan = 1'b0;
    endtask
`endif

    // Monitor for dut1: pops the scoreboard on valid, checks held outputs each cycle.
    initial begin : mon1
        int exp_addr;
        exp_t e;
        exp_addr = 0;
        hold1 = '{0, 0, 0, 0, 0};
        wait (start1);
        forever begin
            @(negedge clock);
            if (cyc == addr_cyc1) exp_addr = addr_pend1;
            if (cyc == rst_cyc1) begin
                exp_addr = 0;
                hold1 = '{0, 0, 0, 0, 0};
            end
            check("mem_wren", {31'd0, w_wren1}, 0);
            check("mem_data", {24'd0, w_data1}, 0);
            check("busy", {31'd0, w_busy1}, (cyc >= busy_from1 && cyc <= busy_to1) ? 1 : 0);
            check("mem_address", {24'd0, w_addr1}, exp_addr);
            if (w_valid1) begin
                if (q1.size() == 0) begin
                    check("unexpected_valid", {31'd0, w_valid1}, 0);
                end else begin
                    e = q1.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    hold1 = e;
                end
            end else if (q1.size() > 0 && cyc > q1[0].cyc) begin
                check("missing_valid", {31'd0, w_valid1}, 1);
                void'(q1.pop_front());
            end
            check("value", {24'd0, w_value1}, hold1.value);
            check("hundreds", {28'd0, w_h1}, hold1.h);
            check("tens", {28'd0, w_t1}, hold1.t);
            check("units", {28'd0, w_u1}, hold1.u);
        end
    end

    // dut2 (RD_LAT=2): simple one-at-a-time reads through its own scoreboard.
    exp_t q2[$];
    bit   done2 = 0;

    initial begin : stim2
        int addrs[6];
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy_dut2", {31'd0, w_busy2}, 0);
        check("reset_value_dut2", {24'd0, w_value2}, 0);
        r_reset2 = 1'b0;
        addrs[0] = 8'h33;
        for (int i = 1; i < 6; i++) addrs[i] = $urandom_range(0, 255);
        for (int i = 0; i < 6; i++) begin
            r_req2      = 1'b1;
            r_req_addr2 = 8'(addrs[i]);
            q2.push_back(make_exp(addrs[i], cyc + 1 + c_L2));
            @(posedge clock); #1;
            r_req2 = 1'b0;
            repeat ($urandom_range(c_L2 + 1, c_L2 + 4)) @(posedge clock);
            #1;
        end
        repeat (20) @(posedge clock);
        if (q2.size() > 0) check("drain_timeout_dut2", q2.size(), 0);
        done2 = 1;
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clock);
            if (w_valid2) begin
                if (q2.size() == 0) begin
                    check("unexpected_valid_dut2", {31'd0, w_valid2}, 0);
                end else begin
                    e = q2.pop_front();
                    check("valid_cycle_dut2", cyc, e.cyc);
                    check("value_dut2", {24'd0, w_value2}, e.value);
                    check("hundreds_dut2", {28'd0, w_h2}, e.h);
                    check("tens_dut2", {28'd0, w_t2}, e.t);
                    check("units_dut2", {28'd0, w_u2}, e.u);
                end
            end else if (q2.size() > 0 && cyc > q2[0].cyc) begin
                check("missing_valid_dut2", {31'd0, w_valid2}, 1);
                void'(q2.pop_front());
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim1
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[8'h05] = 8'hFF;
        ram[8'h00] = 8'h00;
        ram[8'h10] = 8'h09;
        ram[8'h20] = 8'h64;
        ram[8'h33] = 8'h7B;

        repeat (3) @(posedge clock);
        #1;
        start1     = 1;
        r_reset    = 1'b0;
        next_free1 = cyc + 1;

        do_req1(8'h05, 1);
        wait_idle1();
        do_req1(8'h00, 1);
        wait_idle1();
        do_req1(8'h10, 1);
        wait_idle1();

        // Second pulse lands at T+3 while busy and must be dropped.
        do_req1(8'h20, 1);
        @(posedge clock); #1;
        do_req1(8'h05, 1);
        wait_idle1();

        // Reset sampled at T+5, during conversion.
        do_req1(8'h05, 1);
        repeat (3) @(posedge clock);
        #1;
        apply_reset1();
        do_req1(8'h10, 1);
        wait_idle1();

        do_req1(8'h20, 25);
        wait_idle1();

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 12)) @(posedge clock);
            #1;
            if ($urandom_range(0, 9) == 0) apply_reset1();
            else do_req1($urandom_range(0, 255), $urandom_range(1, 3));
        end
        wait_idle1();

`ifdef MEM_READ_DISPLAY_SCAN_EN
        do_req1(8'hFE, 1);
        wait_idle1();
        scan_run(3);
        wait_idle1();
        repeat (15) @(posedge clock);
        #1;
`endif

        n = 0;
        while (!done2 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        if (!done2) check("dut2_timeout", {31'd0, done2}, 1);
        repeat (3) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
